// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: decides per cycle whether the IF/ID and
// ID/EX registers hold or take a bubble (load-use, EX redirects, multi-cycle EX ops with watchdog).
module pipe_hazard_ctrl #(
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_mc_start,
  input  logic             mc_done,
  input  logic             ex_redirect,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WaitW = $clog2(MC_TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {StRun, StMcWait, StFault} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mc_hold;   // multi-cycle op (or fault) holds the whole front end
  logic run_ops;   // evaluate redirect / load-use as in normal flow
  logic redirect;
  logic lu_bubble;

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    mc_hold   = 1'b0;
    run_ops   = 1'b0;
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    case (state_q)
      StRun: begin
        if (ex_mc_start && !mc_done) begin
          mc_hold = 1'b1;
          wait_d  = WaitW'(1);
          state_d = StMcWait;
        end else if (!ex_mc_start) begin
          run_ops = 1'b1;
        end
      end
      StMcWait: begin
        if (!mc_done) begin
          mc_hold = 1'b1;
          if (wait_q == WaitLast) begin
            state_d   = StFault;
            timeout_d = 1'b1;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end else begin
          // Completion cycle behaves like RUN with no new multi-cycle start.
          run_ops = 1'b1;
          state_d = StRun;
        end
      end
      StFault: mc_hold = 1'b1;
      default: state_d = StRun;
    endcase
  end

  assign redirect  = run_ops && ex_redirect;
  assign lu_bubble = run_ops && !ex_redirect && load_use;

  // Gating with rst_n keeps all controls low for the whole reset assertion, not just after an edge.
  assign pc_stall    = rst_n && (mc_hold || lu_bubble);
  assign if_id_stall = rst_n && (mc_hold || lu_bubble);
  assign if_id_flush = rst_n && redirect;
  assign id_ex_stall = rst_n && mc_hold;
  assign id_ex_flush = rst_n && (redirect || lu_bubble);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mc_timeout = timeout_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
